cpu_debug_ocimem_master: RTL and testbench
==========================================

// Module: cpu_debug_ocimem_master
// PURPOSE
//  Consumes the sysclk-domain command strobes and the 38-bit jdo word from the
//  debug-slave sysclk stage, and executes debug memory reads/writes as an
//  Avalon-MM master. It returns MonDReg, monitor_ready and monitor_error to the
//  debug-slave tck stage, closing the JTAG monitor loop. Single clock domain (clk).
// PARAMETERS
//  ADDR_W       8     word-address width; byte address = {MonAReg,2'b00}
//  TIMEOUT_CYC  1023  max cycles per bus transaction before abort (>=2)
// PORTS
//  clk                      in   1       system clock
//  reset                    in   1       synchronous, active-high reset
//  jdo                      in   38      command payload from sysclk stage
//  take_action_ocimem_a     in   1       1-cycle strobe: addr load and/or read
//  take_no_action_ocimem_a  in   1       1-cycle strobe: streaming read, post-inc
//  take_action_ocimem_b     in   1       1-cycle strobe: write, post-inc
//  avm_address              out  ADDR_W+2 byte address
//  avm_read                 out  1       Avalon read request
//  avm_write                out  1       Avalon write request
//  avm_writedata            out  32      write data
//  avm_byteenable           out  4       constant 4'hF
//  avm_waitrequest          in   1       slave stall
//  avm_readdata             in   32      read data
//  avm_readdatavalid        in   1       read data qualifier (pipelined read)
//  MonAReg                  out  ADDR_W  current word address
//  MonDReg                  out  32      last read data / last write data
//  monitor_ready            out  1       1 = idle, can accept a command
//  monitor_error            out  1       sticky error flag
// BEHAVIOUR
//  Reset: state IDLE; MonAReg=0, MonDReg=0, avm_read=avm_write=0,
//   monitor_ready=1, monitor_error=0, timeout counter=0. A reset mid-transaction
//   drops avm_read/avm_write the next edge; an in-flight readdatavalid is ignored.
//  jdo fields: [35] read-enable, [34] address-load, [25:18] address (ADDR_W LSBs
//   of [17+ADDR_W:18]), [34:3] write data (ocimem_b only).
//  Strobe priority if >1 asserted: ocimem_b > ocimem_a > no_action_ocimem_a.
//  Commands are accepted only in IDLE. A strobe outside IDLE is dropped and sets
//   monitor_error. Any accepted command clears monitor_error in the same edge.
//  ocimem_a: jdo[34]=1 -> MonAReg<=jdo addr. jdo[35]=1 -> start read at the new
//   address (load first when both bits set). Neither bit set -> no bus op.
//  no_action_ocimem_a: read at MonAReg; MonAReg+=1 when the data returns.
//  ocimem_b: MonDReg<=jdo[34:3]; write to MonAReg; MonAReg+=1 on acceptance.
//  MonAReg increments modulo 2^ADDR_W: 0xFF -> 0x00 at ADDR_W=8.
//  FSM: IDLE -> RD_REQ (avm_read=1 until !waitrequest) -> RD_WAIT (until
//   readdatavalid; MonDReg<=readdata) -> IDLE.
//   IDLE -> WR_REQ (avm_write=1 until !waitrequest) -> IDLE.
//   If readdatavalid arrives in the same cycle as read acceptance, go directly
//   to IDLE.
//  monitor_ready = (state==IDLE), registered. It falls the edge after a strobe
//   and rises the edge after completion. Minimum latency with waitrequest=0:
//   write 2 clks, read 3 clks from strobe to monitor_ready=1.
//  Timeout: the counter runs in RD_REQ/RD_WAIT/WR_REQ and resets on each state
//   entry. At TIMEOUT_CYC: deassert the request, set monitor_error, go to IDLE.
//   MonDReg and MonAReg are unchanged on abort.
//  avm_address/avm_writedata are stable while a request is asserted.
// STRUCTURE
//  Shared include cpu_debug_defs.vh: FSM state encodings (IDLE/RD_REQ/RD_WAIT/
//   WR_REQ) and jdo bit-index localparams. The debug-slave sysclk stage reuses it.
//  Sub-module cpu_debug_timeout_ctr (clear, enable, terminal-count out,
//   param TIMEOUT_CYC). All other logic is flat in this module.
// TESTING
//  1 ocimem_a jdo[34]=1,jdo[35]=1,addr=0x10; slave returns 0xCAFEF00D ->
//    avm_address=0x040, MonDReg=0xCAFEF00D, MonAReg=0x10, ready high in 3 clks.
//  2 MonAReg=0xFF, ocimem_b data 0x12345678 -> avm_write at 0x3FC,
//    writedata 0x12345678, MonAReg=0x00 after.
//  3 waitrequest held 1 for 1100 clks during a read -> abort at 1023 clks,
//    avm_read=0, monitor_error=1, MonDReg unchanged, then a new read clears error.
//  4 ocimem_b strobe while in RD_WAIT -> command dropped, no write issued,
//    monitor_error=1, the read completes normally.
//  5 ocimem_a and ocimem_b in the same cycle -> only the write executes.
//  6 reset asserted in WR_REQ with waitrequest=1 -> next edge avm_write=0,
//    state IDLE, all outputs at reset values.

Source files
------------

// File: rtl/cpu_debug_ocimem_master_pkg.sv
// Shared definitions for the debug OCI memory master: FSM encodings and jdo field positions.
// The debug-slave sysclk stage imports the same package.
package cpu_debug_ocimem_master_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRdReq  = 2'd1,
    StRdWait = 2'd2,
    StWrReq  = 2'd3
  } state_e;

  localparam int unsigned JdoRdEn     = 35;
  localparam int unsigned JdoAddrLd   = 34;
  localparam int unsigned JdoAddrLsb  = 18;
  localparam int unsigned JdoWdataLsb = 3;
  localparam int unsigned JdoWdataW   = 32;

endpackage

// File: rtl/cpu_debug_timeout_ctr.sv
// Per-transaction cycle counter; tc flags the last permitted cycle of a bus transaction.
module cpu_debug_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] Last = CntW'(TIMEOUT_CYC - 1);

  logic [CntW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CntW'(1);
    end
  end

  assign tc = (cnt == Last);

endmodule

// File: rtl/cpu_debug_ocimem_master.sv
// Executes JTAG-monitor memory reads/writes as an Avalon-MM master and reports
// MonAReg/MonDReg/ready/error back to the debug slave.
module cpu_debug_ocimem_master
  import cpu_debug_ocimem_master_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [ADDR_W+1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [ADDR_W-1:0] MonAReg,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  state_e            state;
  logic              rd_inc;
  logic              any_strobe;
  logic              ctr_clear;
  logic              ctr_en;
  logic              ctr_tc;
  logic [ADDR_W-1:0] jdo_addr;
  logic [31:0]       jdo_wdata;
  logic [ADDR_W-1:0] rd_addr;
  logic              unused_jdo;

  assign jdo_addr       = jdo[JdoAddrLsb +: ADDR_W];
  assign jdo_wdata      = jdo[JdoWdataLsb +: JdoWdataW];
  assign unused_jdo     = ^{jdo[37:36], jdo[2:0]};
  assign any_strobe     = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign avm_byteenable = 4'hF;
  // Address load happens in the same edge as the read launch, so the read uses the new value.
  assign rd_addr        = jdo[JdoAddrLd] ? jdo_addr : MonAReg;

  // The counter restarts on entry to each busy state, including RD_REQ -> RD_WAIT.
  assign ctr_clear = (state == StIdle) || (state == StRdReq && !avm_waitrequest);
  assign ctr_en    = (state != StIdle);

  cpu_debug_timeout_ctr #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout_ctr (
    .clk   (clk),
    .reset (reset),
    .clear (ctr_clear),
    .enable(ctr_en),
    .tc    (ctr_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= StIdle;
      rd_inc        <= 1'b0;
      avm_address   <= '0;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_writedata <= '0;
      MonAReg       <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (take_action_ocimem_b) begin
            monitor_error <= 1'b0;
            MonDReg       <= jdo_wdata;
            avm_writedata <= jdo_wdata;
            avm_address   <= {MonAReg, 2'b00};
            avm_write     <= 1'b1;
            monitor_ready <= 1'b0;
            state         <= StWrReq;
          end else if (take_action_ocimem_a) begin
            monitor_error <= 1'b0;
            if (jdo[JdoAddrLd]) begin
              MonAReg <= jdo_addr;
            end
            if (jdo[JdoRdEn]) begin
              avm_address   <= {rd_addr, 2'b00};
              avm_read      <= 1'b1;
              rd_inc        <= 1'b0;
              monitor_ready <= 1'b0;
              state         <= StRdReq;
            end
          end else if (take_no_action_ocimem_a) begin
            monitor_error <= 1'b0;
            avm_address   <= {MonAReg, 2'b00};
            avm_read      <= 1'b1;
            rd_inc        <= 1'b1;
            monitor_ready <= 1'b0;
            state         <= StRdReq;
          end
        end
        StRdReq: begin
          if (!avm_waitrequest) begin
            avm_read <= 1'b0;
            if (avm_readdatavalid) begin
              MonDReg       <= avm_readdata;
              MonAReg       <= rd_inc ? MonAReg + ADDR_W'(1) : MonAReg;
              monitor_ready <= 1'b1;
              state         <= StIdle;
            end else begin
              state <= StRdWait;
            end
          end else if (ctr_tc) begin
            avm_read      <= 1'b0;
            monitor_error <= 1'b1;
            monitor_ready <= 1'b1;
            state         <= StIdle;
          end
        end
        StRdWait: begin
          if (avm_readdatavalid) begin
            MonDReg       <= avm_readdata;
            MonAReg       <= rd_inc ? MonAReg + ADDR_W'(1) : MonAReg;
            monitor_ready <= 1'b1;
            state         <= StIdle;
          end else if (ctr_tc) begin
            monitor_error <= 1'b1;
            monitor_ready <= 1'b1;
            state         <= StIdle;
          end
        end
        StWrReq: begin
          if (!avm_waitrequest) begin
            avm_write     <= 1'b0;
            MonAReg       <= MonAReg + ADDR_W'(1);
            monitor_ready <= 1'b1;
            state         <= StIdle;
          end else if (ctr_tc) begin
            avm_write     <= 1'b0;
            monitor_error <= 1'b1;
            monitor_ready <= 1'b1;
            state         <= StIdle;
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase
      // A command arriving while busy is dropped but flagged.
      if (state != StIdle && any_strobe) begin
        monitor_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_debug_ocimem_master.sv
// Directed and randomized checks of the debug OCI memory master against a word-level
// model of monitor address/data/memory state.
module tb_cpu_debug_ocimem_master;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_no_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic [9:0]  avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic [7:0]  MonAReg;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  cpu_debug_ocimem_master dut (
    .clk                    (clk),
    .reset                  (reset),
    .jdo                    (jdo),
    .take_action_ocimem_a   (take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b   (take_action_ocimem_b),
    .avm_address            (avm_address),
    .avm_read               (avm_read),
    .avm_write              (avm_write),
    .avm_writedata          (avm_writedata),
    .avm_byteenable         (avm_byteenable),
    .avm_waitrequest        (avm_waitrequest),
    .avm_readdata           (avm_readdata),
    .avm_readdatavalid      (avm_readdatavalid),
    .MonAReg                (MonAReg),
    .MonDReg                (MonDReg),
    .monitor_ready          (monitor_ready),
    .monitor_error          (monitor_error)
  );

  always #5 clk = ~clk;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  int          wr_mode = 1;   // 0 random stalls, 1 never stall, 2 always stall
  int          lat_fix = 1;   // fixed read latency, or -1 for random 0..2
  int          pend_cnt = 0;
  logic [7:0]  pend_addr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Plays the Avalon slave for one cycle, then advances to #1 after the next edge.
  task automatic cycle();
    int lat;
    avm_readdatavalid = 1'b0;
    avm_readdata      = $urandom();
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = mem[pend_addr];
      end
    end
    case (wr_mode)
      0:       avm_waitrequest = ($urandom_range(0, 3) == 0);
      1:       avm_waitrequest = 1'b0;
      default: avm_waitrequest = 1'b1;
    endcase
    if (avm_read === 1'b1 && !avm_waitrequest) begin
      lat = (lat_fix < 0) ? int'($urandom_range(0, 2)) : lat_fix;
      if (lat == 0) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = mem[avm_address[9:2]];
      end else begin
        pend_cnt  = lat;
        pend_addr = avm_address[9:2];
      end
    end
    if (avm_write === 1'b1 && !avm_waitrequest) mem[avm_address[9:2]] = avm_writedata;
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic a, input logic na, input logic b, input logic [37:0] j);
    jdo                     = j;
    take_action_ocimem_a    = a;
    take_no_action_ocimem_a = na;
    take_action_ocimem_b    = b;
    cycle();
    take_action_ocimem_a    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b    = 1'b0;
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (!monitor_ready && n < budget) begin
      cycle();
      n++;
    end
    check("ready_within_budget", monitor_ready, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [37:0] j;
    logic [63:0] r64;
    logic [31:0] val;
    logic [7:0]  ref_a;
    logic [31:0] ref_d;
    logic        sa, sna, sb, saw_wr;
    int          n, k;

    reset = 1'b1;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    avm_waitrequest = 1'b0;
    avm_readdata = '0;
    avm_readdatavalid = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom();
    @(posedge clk);
    #1;
    cycle();
    cycle();
    reset = 1'b0;

    // Reset state
    check("rst_ready", monitor_ready, 1'b1);
    check("rst_error", monitor_error, 1'b0);
    check("rst_read", avm_read, 1'b0);
    check("rst_write", avm_write, 1'b0);
    check("rst_areg", MonAReg, 8'h00);
    check("rst_dreg", MonDReg, 32'h0);
    check("byteenable", avm_byteenable, 4'hF);

    // 1: load address 0x10 and read it
    mem[8'h10] = 32'hCAFEF00D;
    j = '0; j[35] = 1'b1; j[34] = 1'b1; j[25:18] = 8'h10;
    strobe(1'b1, 1'b0, 1'b0, j);
    check("t1_read_req", avm_read, 1'b1);
    check("t1_address", avm_address, 10'h040);
    check("t1_ready_low", monitor_ready, 1'b0);
    cycle();
    check("t1_ready_low2", monitor_ready, 1'b0);
    cycle();
    check("t1_ready_3clk", monitor_ready, 1'b1);
    check("t1_dreg", MonDReg, 32'hCAFEF00D);
    check("t1_areg", MonAReg, 8'h10);

    // 2: write at 0xFF wraps MonAReg to 0
    j = '0; j[34] = 1'b1; j[25:18] = 8'hFF;
    strobe(1'b1, 1'b0, 1'b0, j);
    check("t2_load_areg", MonAReg, 8'hFF);
    check("t2_load_ready", monitor_ready, 1'b1);
    j = '0; j[34:3] = 32'h12345678;
    strobe(1'b0, 1'b0, 1'b1, j);
    check("t2_write_req", avm_write, 1'b1);
    check("t2_address", avm_address, 10'h3FC);
    check("t2_wdata", avm_writedata, 32'h12345678);
    cycle();
    check("t2_ready_2clk", monitor_ready, 1'b1);
    check("t2_write_done", avm_write, 1'b0);
    check("t2_areg_wrap", MonAReg, 8'h00);
    check("t2_dreg", MonDReg, 32'h12345678);
    check("t2_mem", mem[8'hFF], 32'h12345678);

    // 3: read held off forever aborts after 1023 cycles
    wr_mode = 2;
    strobe(1'b0, 1'b1, 1'b0, 38'h0);
    n = 0;
    while (avm_read && n < 1100) begin
      n++;
      cycle();
    end
    check("t3_abort_cycles", n, 1023);
    check("t3_read_low", avm_read, 1'b0);
    check("t3_error", monitor_error, 1'b1);
    check("t3_ready", monitor_ready, 1'b1);
    check("t3_dreg_kept", MonDReg, 32'h12345678);
    check("t3_areg_kept", MonAReg, 8'h00);
    wr_mode = 1;
    val = $urandom();
    mem[0] = val;
    j = '0; j[35] = 1'b1;
    strobe(1'b1, 1'b0, 1'b0, j);
    check("t3_error_cleared", monitor_error, 1'b0);
    wait_ready(20);
    check("t3_new_read", MonDReg, val);
    check("t3_new_areg", MonAReg, 8'h00);

    // 4: write strobe during RD_WAIT is dropped
    lat_fix = 4;
    val = $urandom();
    mem[0] = val;
    strobe(1'b0, 1'b1, 1'b0, 38'h0);
    cycle();
    check("t4_in_rdwait", monitor_ready, 1'b0);
    j = '0; j[34:3] = 32'h0BADBEEF;
    strobe(1'b0, 1'b0, 1'b1, j);
    check("t4_error_set", monitor_error, 1'b1);
    saw_wr = 1'b0;
    n = 0;
    while (!monitor_ready && n < 20) begin
      if (avm_write) saw_wr = 1'b1;
      cycle();
      n++;
    end
    check("t4_ready", monitor_ready, 1'b1);
    check("t4_no_write", saw_wr, 1'b0);
    check("t4_error_sticky", monitor_error, 1'b1);
    check("t4_dreg", MonDReg, val);
    check("t4_areg_inc", MonAReg, 8'h01);
    lat_fix = 1;

    // 5: ocimem_a and ocimem_b together -> only the write
    val = 32'h9ABCDEF1;
    j = '0; j[34:3] = val; j[35] = 1'b1;
    strobe(1'b1, 1'b0, 1'b1, j);
    check("t5_write", avm_write, 1'b1);
    check("t5_no_read", avm_read, 1'b0);
    check("t5_address", avm_address, 10'h004);
    check("t5_error_cleared", monitor_error, 1'b0);
    cycle();
    check("t5_ready", monitor_ready, 1'b1);
    check("t5_areg", MonAReg, 8'h02);
    check("t5_dreg", MonDReg, val);

    // 6: reset during a stalled write
    wr_mode = 2;
    j = '0; j[34:3] = 32'h55AA55AA;
    strobe(1'b0, 1'b0, 1'b1, j);
    check("t6_write_req", avm_write, 1'b1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    pend_cnt = 0;
    check("t6_write_low", avm_write, 1'b0);
    check("t6_read_low", avm_read, 1'b0);
    check("t6_ready", monitor_ready, 1'b1);
    check("t6_error", monitor_error, 1'b0);
    check("t6_areg", MonAReg, 8'h00);
    check("t6_dreg", MonDReg, 32'h0);

    // Randomized commands against the word-level model
    wr_mode = 0;
    lat_fix = -1;
    ref_a = 8'h00;
    ref_d = 32'h0;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    for (int it = 0; it < 80; it++) begin
      k = $urandom_range(0, 9);
      r64 = {$urandom(), $urandom()};
      j = r64[37:0];
      sa  = (k <= 2) || (k == 9);
      sna = (k >= 3 && k <= 5) || (k == 9);
      sb  = (k >= 6);
      if (sb) begin
        ref_d = j[34:3];
        ref_mem[ref_a] = ref_d;
        ref_a = ref_a + 8'd1;
      end else if (sa) begin
        if (j[34]) ref_a = j[25:18];
        if (j[35]) ref_d = ref_mem[ref_a];
      end else begin
        ref_d = ref_mem[ref_a];
        ref_a = ref_a + 8'd1;
      end
      strobe(sa, sna, sb, j);
      wait_ready(40);
      check("rnd_areg", MonAReg, ref_a);
      check("rnd_dreg", MonDReg, ref_d);
      check("rnd_error", monitor_error, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
